// File: rtl/core_pkg.sv
// Shared core types for the AMO sequencer: op/ALU/memory/exception encodings,
// AMO FSM states and the AMO-to-ALU op mapping helpers.
package core_pkg;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_AND  = 5'd4,
    ALU_MIN  = 5'd5,
    ALU_MAX  = 5'd6,
    ALU_MINU = 5'd7,
    ALU_MAXU = 5'd8,
    ALU_OB   = 5'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_EXEC     = 2'd0,
    MEM_READ     = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_READ_AMO = 2'd3
  } mem_dir_e;

  typedef enum logic [5:0] {
    EX_INSTR_MISALIGNED   = 6'd0,
    EX_ILLEGAL_INSTR      = 6'd2,
    EX_LOAD_MISALIGNED    = 6'd4,
    EX_LOAD_ACCESS_FAULT  = 6'd5,
    EX_STORE_MISALIGNED   = 6'd6,
    EX_STORE_ACCESS_FAULT = 6'd7
  } exception_e;

  typedef enum logic [2:0] {
    AMO_S_IDLE,
    AMO_S_READ,
    AMO_S_EXEC,
    AMO_S_WRITE,
    AMO_S_RESP
  } amo_state_e;

  function automatic logic amo_is_valid(amo_op_e op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e amo_to_alu_op(amo_op_e op);
    case (op)
      AMO_SWAP: return ALU_OB;
      AMO_XOR:  return ALU_XOR;
      AMO_OR:   return ALU_OR;
      AMO_AND:  return ALU_AND;
      AMO_MIN:  return ALU_MIN;
      AMO_MAX:  return ALU_MAX;
      AMO_MINU: return ALU_MINU;
      AMO_MAXU: return ALU_MAXU;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_amo_rsv.sv
// LR/SC reservation: valid bit plus word address. rsv_clear beats a same-cycle
// set and also masks the match so an SC issued alongside it fails.
module core_amo_rsv (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsv_set,
  input  logic [29:0] set_addr,
  input  logic        sc_clr,
  input  logic        rsv_clear,
  input  logic [29:0] cmp_addr,
  output logic        match
);

  logic        valid_q, valid_d;
  logic [29:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (rsv_clear || sc_clr) begin
      valid_d = 1'b0;
    end else if (rsv_set) begin
      valid_d = 1'b1;
      addr_d  = set_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign match = valid_q && !rsv_clear && (addr_q == cmp_addr);

endmodule

// File: rtl/core_amo_ctrl.sv
// RV32A AMO sequencer: LR, SC and read-modify-write through READ/EXEC/WRITE.
// Optional issue-time misalignment trap: define CORE_AMO_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready, waiting for start
// READ  | memory read outstanding (LR / RMW)
// EXEC  | shared ALU computes the store value
// WRITE | memory write outstanding (RMW / passing SC)
// RESP  | done pulse with rd / exception
module core_amo_ctrl
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [4:0]  amo_op,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  input  logic        rsv_clear,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        exc_valid,
  output logic [5:0]  exc_cause,
  output logic        mem_req,
  output logic [1:0]  mem_dir,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);

  amo_state_e  state_q, state_d;
  amo_op_e     op_q, op_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] load_q, load_d;
  logic [31:0] rd_q, rd_d;
  logic        exc_valid_q, exc_valid_d;
  exception_e  exc_cause_q, exc_cause_d;
  logic        mem_req_q, mem_req_d;
  mem_dir_e    mem_dir_q, mem_dir_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  amo_op_e op_in;
  logic    misaligned;
  logic    rsv_set, rsv_sc_clr, rsv_match;

  assign op_in = amo_op_e'(amo_op);

`ifdef CORE_AMO_MISALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];
  assign misaligned       = 1'b0;
`endif

  core_amo_rsv u_rsv (
    .clk       (clk),
    .rst       (rst),
    .rsv_set   (rsv_set),
    .set_addr  (mem_addr_q[31:2]),
    .sc_clr    (rsv_sc_clr),
    .rsv_clear (rsv_clear),
    .cmp_addr  (addr[31:2]),
    .match     (rsv_match)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs2_d       = rs2_q;
    load_d      = load_q;
    rd_d        = rd_q;
    exc_valid_d = exc_valid_q;
    exc_cause_d = exc_cause_q;
    mem_req_d   = mem_req_q;
    mem_dir_d   = mem_dir_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsv_set     = 1'b0;
    rsv_sc_clr  = 1'b0;

    case (state_q)
      AMO_S_IDLE: begin
        if (start) begin
          op_d        = op_in;
          rs2_d       = rs2_data;
          mem_addr_d  = {addr[31:2], 2'b00};
          rd_d        = '0;
          exc_valid_d = 1'b0;
          exc_cause_d = EX_INSTR_MISALIGNED;
          if (!amo_is_valid(op_in)) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EX_ILLEGAL_INSTR;
            state_d     = AMO_S_RESP;
          end else if (misaligned) begin
            exc_valid_d = 1'b1;
            if (op_in == AMO_LR) exc_cause_d = EX_LOAD_MISALIGNED;
            else                 exc_cause_d = EX_STORE_MISALIGNED;
            state_d     = AMO_S_RESP;
          end else if (op_in == AMO_SC) begin
            // Every aligned SC consumes the reservation, pass or fail.
            rsv_sc_clr = 1'b1;
            if (rsv_match) begin
              mem_req_d   = 1'b1;
              mem_dir_d   = MEM_WRITE;
              mem_wdata_d = rs2_data;
              state_d     = AMO_S_WRITE;
            end else begin
              rd_d    = 32'd1;
              state_d = AMO_S_RESP;
            end
          end else begin
            mem_req_d = 1'b1;
            mem_dir_d = MEM_READ_AMO;
            state_d   = AMO_S_READ;
          end
        end
      end

      AMO_S_READ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          load_d    = mem_rdata;
          if (mem_err) begin
            exc_valid_d = 1'b1;
            if (op_q == AMO_LR) exc_cause_d = EX_LOAD_ACCESS_FAULT;
            else                exc_cause_d = EX_STORE_ACCESS_FAULT;
            rd_d        = '0;
            state_d     = AMO_S_RESP;
          end else if (op_q == AMO_LR) begin
            rd_d    = mem_rdata;
            rsv_set = 1'b1;
            state_d = AMO_S_RESP;
          end else begin
            rd_d    = mem_rdata;
            state_d = AMO_S_EXEC;
          end
        end
      end

      AMO_S_EXEC: begin
        mem_wdata_d = alu_result;
        mem_req_d   = 1'b1;
        mem_dir_d   = MEM_WRITE;
        state_d     = AMO_S_WRITE;
      end

      AMO_S_WRITE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_err) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EX_STORE_ACCESS_FAULT;
            rd_d        = '0;
          end
          state_d = AMO_S_RESP;
        end
      end

      AMO_S_RESP: state_d = AMO_S_IDLE;

      default: state_d = AMO_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AMO_S_IDLE;
      op_q        <= AMO_ADD;
      rs2_q       <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= EX_INSTR_MISALIGNED;
      mem_req_q   <= 1'b0;
      mem_dir_q   <= MEM_EXEC;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs2_q       <= rs2_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      mem_req_q   <= mem_req_d;
      mem_dir_q   <= mem_dir_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready     = (state_q == AMO_S_IDLE);
  assign done      = (state_q == AMO_S_RESP);
  assign rd_data   = rd_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign mem_req   = mem_req_q;
  assign mem_dir   = mem_dir_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_op    = (state_q == AMO_S_EXEC) ? amo_to_alu_op(op_q) : ALU_ADD;
  assign alu_a     = load_q;
  assign alu_b     = rs2_q;

endmodule

// File: doc/core_amo_ctrl.md
# core_amo_ctrl

Sequencer for RV32A atomic instructions on the CTRL_AMO path. Takes a decoded AMO (LR, SC, or read-modify-write), drives the core memory port through read, ALU compute and write phases, owns the LR/SC reservation, and returns the rd value or an exception. Sits between decode/issue and the data-memory interface, borrowing the shared ALU during its EXEC phase.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue strobe, accepted only when ready=1
- ready  out  1  controller idle
- amo_op  in  5  amo_op_e, sampled at start
- addr  in  32  rs1 value, sampled at start
- rs2_data  in  32  rs2 value, sampled at start
- rsv_clear  in  1  trap/xRET/external invalidate; kills the reservation
- done  out  1  one-cycle completion pulse
- rd_data  out  32  rd writeback value, valid with done
- exc_valid  out  1  exception flag, valid with done
- exc_cause  out  6  exception_e, valid with done
- mem_req  out  1  memory request
- mem_dir  out  2  mem_dir_e: MEM_READ_AMO (LR and RMW read) or MEM_WRITE
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  store data
- mem_ack  in  1  request completes this cycle
- mem_err  in  1  access fault, qualified by mem_ack
- mem_rdata  in  32  read data, qualified by mem_ack
- alu_op  out  5  alu_op_e for the shared ALU
- alu_a  out  32  captured memory value
- alu_b  out  32  captured rs2
- alu_result  in  32  combinational ALU result

## Operation
- States: IDLE, READ, EXEC, WRITE, RESP. ready=1 only in IDLE.
- Issue decoding: illegal amo_op goes to RESP with EX_ILLEGAL_INSTR. LR goes to READ. SC goes to WRITE when the reservation is valid and rsv_addr matches addr[31:2], otherwise to RESP with rd=1. Every other op goes to READ.
- READ: mem_req=1, dir MEM_READ_AMO, held until mem_ack. On ack, mem_rdata is captured into the load register. Next state is RESP for LR and EXEC for RMW ops.
- LR on a READ ack with no error: reservation set with rsv_addr=addr[31:2].
- EXEC: one cycle. Op mapping: SWAP→ALU_OB, ADD→ALU_ADD, XOR→ALU_XOR, OR→ALU_OR, AND→ALU_AND, MIN/MAX/MINU/MAXU→ALU_MIN/MAX/MINU/MAXU. alu_result is latched into the write-data register. alu_op outputs ALU_ADD outside EXEC.
- WRITE: mem_req=1, dir MEM_WRITE, wdata is the latched result (rs2 for SC), held until mem_ack, then RESP.
- SC results: rd=0 on a successful write, rd=1 on failure. The reservation is cleared on every SC whether it passes or fails.
- RMW and LR results: rd is the value loaded in READ.
- RESP: done=1 for one cycle, then IDLE. When exc_valid=1, rd_data is 0.
- Memory faults:
  - mem_err with ack in READ gives EX_LOAD_ACCESS_FAULT for LR and EX_STORE_ACCESS_FAULT for RMW.
  - mem_err with ack in WRITE gives EX_STORE_ACCESS_FAULT.
  - A faulting op never modifies the reservation; SC still clears it.
- rsv_clear clears the reservation in any state.
  - It wins over an LR set in the same cycle.
  - It also wins when asserted in the cycle an SC is accepted, so that SC fails.

## Timing
- Reset values: state IDLE, ready=1, done=0, exc_valid=0, exc_cause=0, rd_data=0, mem_req=0, mem_dir=MEM_EXEC, mem_addr=0, mem_wdata=0, alu_op=ALU_ADD, alu_a=0, alu_b=0, reservation invalid.
- mem_req, mem_dir, mem_addr and mem_wdata are registered and stay stable until ack. There is no request in the cycle after an ack.
- Latency with zero wait states (ack on the first mem_req cycle), start accepted at cycle T:
  - RMW: done at T+4.
  - LR: done at T+2.
  - SC pass: done at T+2.
  - SC fail or illegal op: done at T+1.
- Each memory wait cycle adds one cycle.
- Back-to-back: start may be asserted again in the cycle after done.
- Reset mid-operation drops mem_req asynchronously and abandons the operation. No done is generated.

## Configuration
- CORE_AMO_MISALIGN_CHECK_EN defined: at issue, addr[1:0]≠0 skips memory entirely and goes to RESP. Cause is EX_LOAD_MISALIGNED for LR and EX_STORE_MISALIGNED for SC/RMW. The reservation is untouched.
- Macro undefined: addr[1:0] is ignored and the access proceeds word-aligned.
- Illegal-op checking takes priority over the misalign check.

## Structure
- core_pkg additions:
  - amo_state_e enum (the five states).
  - Function amo_to_alu_op(amo_op_e) returning alu_op_e.
  - Function amo_is_valid(amo_op_e).
- Sub-module core_amo_rsv holds the reservation valid bit and 30-bit address, with set, clear, rsv_clear priority and a match output. The FSM stays in core_amo_ctrl.

## Test plan
- AMOADD.W, mem[0x100]=5, rs2=3, zero-wait → done at T+4, rd=5, write of 8 to 0x100.
- LR.W 0x200 (mem=0xAA), then SC.W 0x200 rs2=7 → LR rd=0xAA; SC rd=0 at T+2, writes 7. A second SC → rd=1, done at T+1, no mem_req.
- LR.W 0x200, rsv_clear pulse, SC.W 0x200 → SC rd=1, no write.
- AMOMAXU.W with mem=0xFFFFFFFF, rs2=1, 3 wait states per access → writes 0xFFFFFFFF, rd=0xFFFFFFFF, done at T+10.
- AMOSWAP.W with mem_err on READ → exc_valid=1, cause 7, no WRITE. LR with mem_err → cause 5.
- With the macro defined, AMOOR.W addr 0x102 → cause 6 at T+1, no mem_req. Without the macro, mem_addr=0x100. Illegal amo_op 5'b00110 → cause 2.
